rst_seq_ctrl: RTL and testbench

Parametrised reset sequencer sitting between the SoC clock/reset pins and the per-subsystem reset inputs of `azadi_soc_top`. It generalises a single fixed-length reset pulse into N independently released reset domains with staggered release, a per-domain ready handshake, a bring-up timeout, and software-requested re-reset. It replaces ad-hoc bench reset generation and is synthesizable for silicon bring-up.

---
 rtl/rst_seq_ctrl_pkg.sv | 20 ++
 rtl/rst_seq_ctrl_if.sv | 35 +++
 rtl/rst_seq_ctrl_counter.sv | 32 +++
 rtl/rst_seq_ctrl.sv | 127 ++++++++++++
 tb/tb_rst_seq_ctrl.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/rst_seq_ctrl_pkg.sv
// Shared types and helpers for the reset sequencer: FSM state encoding,
// debug state width and the counter width function.
package rst_seq_pkg;

    localparam int StateW = 3;

    typedef enum logic [StateW-1:0] {
        HOLD     = 3'd0,
        RELEASE  = 3'd1,
        WAIT_ACK = 3'd2,
        RUN      = 3'd3,
        FAIL     = 3'd4
    } rst_seq_state_e;

    // Bits needed to hold values 0..max (at least one bit).
    function automatic int cnt_w(input int max);
        return (max < 1) ? 1 : $clog2(max + 1);
    endfunction

endpackage

// File: rtl/rst_seq_ctrl_if.sv
// Handshake/status bundle between the reset sequencer and the SoC.
// The master side is the sequencer, the slave side is the SoC/bench.
interface rst_seq_ctrl_if
    import rst_seq_pkg::*;
#(
    parameter int NumDomains = 4
);
    logic                  req_i;
    logic [NumDomains-1:0] ack_i;
    logic [NumDomains-1:0] rst_no;
    logic                  busy_o;
    logic                  done_o;
    logic                  timeout_o;
    logic [StateW-1:0]     state_o;

    modport master (
        input  req_i,
        input  ack_i,
        output rst_no,
        output busy_o,
        output done_o,
        output timeout_o,
        output state_o
    );

    modport slave (
        output req_i,
        output ack_i,
        input  rst_no,
        input  busy_o,
        input  done_o,
        input  timeout_o,
        input  state_o
    );
endinterface

// File: rtl/rst_seq_ctrl_counter.sv
// Clear/enable up-counter that saturates at MaxVal, with a terminal-count
// flag comparing the registered count against a run-time value.
module rst_seq_counter
    import rst_seq_pkg::*;
#(
    parameter int MaxVal = 1,
    parameter int W      = cnt_w(MaxVal)
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] tc_val_i,
    output logic         tc_o
);

    logic [W-1:0] cnt_reg;

    // Count up while enabled; clear wins over enable; stop at MaxVal.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_reg <= '0;
        end else if (clr_i) begin
            cnt_reg <= '0;
        end else if (en_i && (cnt_reg != W'(MaxVal))) begin
            cnt_reg <= cnt_reg + W'(1);
        end
    end

    assign tc_o = (cnt_reg == tc_val_i);

endmodule

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: holds all domains in reset, releases them one by one
// with a fixed stagger, waits for every domain to report ready, and
// falls into a sticky FAIL state if bring-up overruns its budget.
module rst_seq_ctrl
    import rst_seq_pkg::*;
#(
    parameter int NumDomains    = 4,
    parameter int HoldCycles    = 25,
    parameter int StaggerCycles = 4,
    parameter int TimeoutCycles = 200
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    rst_seq_ctrl_if.master bus
);

    // The hold/stagger counter serves both phases, so size it for the longer.
    localparam int SeqMax = (HoldCycles > StaggerCycles) ? HoldCycles : StaggerCycles;
    localparam int SeqW   = cnt_w(SeqMax);
    localparam int ToW    = cnt_w(TimeoutCycles);

    rst_seq_state_e        state_reg;
    logic [NumDomains-1:0] rst_n_reg;
    logic                  busy_reg;
    logic                  done_reg;
    logic                  timeout_reg;

    logic                  seq_en;
    logic                  seq_clr;
    logic                  seq_tc;
    logic [SeqW-1:0]       seq_tc_val;
    logic                  to_en;
    logic                  to_tc;
    logic                  all_ack;
    logic                  entering_run;
    logic                  timeout_hit;
    logic [NumDomains:0]   shifted_mask;
    logic [NumDomains-1:0] rst_n_next;

    // Counter controls and next release mask (domains release in index
    // order, so the mask is a thermometer code and one more 1 shifts in).
    always_comb begin
        seq_en       = (state_reg == HOLD) || (state_reg == RELEASE);
        seq_tc_val   = (state_reg == HOLD) ? SeqW'(HoldCycles - 1) : SeqW'(StaggerCycles - 1);
        seq_clr      = bus.req_i || (seq_en && seq_tc);
        to_en        = (state_reg == HOLD) || (state_reg == RELEASE) || (state_reg == WAIT_ACK);
        all_ack      = &bus.ack_i;
        entering_run = (state_reg == WAIT_ACK) && all_ack;
        // Completion on the timeout edge wins over the timeout.
        timeout_hit  = to_en && to_tc && !entering_run;
        shifted_mask = {rst_n_reg, 1'b1};
        rst_n_next   = shifted_mask[NumDomains-1:0];
    end

    rst_seq_counter #(
        .MaxVal (SeqMax)
    ) u_seq_cnt (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clr_i    (seq_clr),
        .en_i     (seq_en),
        .tc_val_i (seq_tc_val),
        .tc_o     (seq_tc)
    );

    rst_seq_counter #(
        .MaxVal (TimeoutCycles)
    ) u_to_cnt (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clr_i    (bus.req_i),
        .en_i     (to_en),
        .tc_val_i (ToW'(TimeoutCycles - 1)),
        .tc_o     (to_tc)
    );

    // Sequencer FSM with registered outputs; reset > request > timeout > normal flow.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || bus.req_i) begin
            state_reg   <= HOLD;
            rst_n_reg   <= '0;
            busy_reg    <= 1'b1;
            done_reg    <= 1'b0;
            timeout_reg <= 1'b0;
        end else if (timeout_hit) begin
            state_reg   <= FAIL;
            rst_n_reg   <= '0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            timeout_reg <= 1'b1;
        end else begin
            case (state_reg)
                HOLD: begin
                    if (seq_tc) begin
                        rst_n_reg <= rst_n_next;
                        state_reg <= (NumDomains == 1) ? WAIT_ACK : RELEASE;
                    end
                end
                RELEASE: begin
                    if (seq_tc) begin
                        rst_n_reg <= rst_n_next;
                        if (&rst_n_next) begin
                            state_reg <= WAIT_ACK;
                        end
                    end
                end
                WAIT_ACK: begin
                    if (all_ack) begin
                        state_reg <= RUN;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                    end
                end
                default: begin
                    // RUN and FAIL hold until a request or reset.
                end
            endcase
        end
    end

    assign bus.rst_no    = rst_n_reg;
    assign bus.busy_o    = busy_reg;
    assign bus.done_o    = done_reg;
    assign bus.timeout_o = timeout_reg;
    assign bus.state_o   = state_reg;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Bench for rst_seq_ctrl: a 4-domain and a 1-domain instance, directed
// stimulus, an edge-count model checked every cycle, plus literal checks.
module tb_rst_seq_ctrl;

    localparam int H = 25;
    localparam int S = 4;
    localparam int T = 200;

    typedef struct packed {
        logic [3:0] rstn;
        logic       busy;
        logic       done;
        logic       tmo;
        logic [2:0] st;
    } exp_t;

    logic clk = 1'b0;
    logic a_rstn;
    logic b_rstn;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    rst_seq_ctrl_if #(.NumDomains(4)) aif ();
    rst_seq_ctrl_if #(.NumDomains(1)) bif ();

    rst_seq_ctrl #(
        .NumDomains(4), .HoldCycles(H), .StaggerCycles(S), .TimeoutCycles(T)
    ) dut_a (
        .clk_i  (clk),
        .rst_ni (a_rstn),
        .bus    (aif)
    );

    rst_seq_ctrl #(
        .NumDomains(1), .HoldCycles(H), .StaggerCycles(S), .TimeoutCycles(T)
    ) dut_b (
        .clk_i  (clk),
        .rst_ni (b_rstn),
        .bus    (bif)
    );

    // Model: e = edges since the last reset/request edge.
    // Domain k is released once e >= H + k*S; the all-ack check applies
    // from the edge after the last release; budget expires at e == T.
    function automatic void mdl_step(input int n, input bit rstn, input bit req,
                                     input bit allack, inout int e,
                                     inout bit run, inout bit fail);
        int rel_end;
        rel_end = H + (n - 1) * S;
        if (!rstn || req) begin
            e = 0; run = 0; fail = 0;
        end else begin
            e = e + 1;
            if (!run && !fail) begin
                if (e > rel_end && allack) run = 1;
                else if (e >= T) fail = 1;
            end
        end
    endfunction

    function automatic exp_t expect_of(input int n, input int e, input bit run, input bit fail);
        exp_t x;
        int   rel_end;
        rel_end = H + (n - 1) * S;
        x = '0;
        for (int k = 0; k < n; k++)
            if (!fail && e >= H + k * S) x.rstn[k] = 1'b1;
        x.busy = !run && !fail;
        x.done = run;
        x.tmo  = fail;
        if (fail)              x.st = 3'd4;
        else if (run)          x.st = 3'd3;
        else if (e < H)        x.st = 3'd0;
        else if (e < rel_end)  x.st = 3'd1;
        else                   x.st = 3'd2;
        return x;
    endfunction

    int a_e = 0, b_e = 0;
    bit a_run = 0, a_fail = 0, a_valid = 0;
    bit b_run = 0, b_fail = 0, b_valid = 0;
    exp_t a_x, a_g, b_x, b_g;

    // Advance the model on every edge from the same inputs the DUTs sample.
    always @(posedge clk) begin
        mdl_step(4, a_rstn, aif.req_i, &aif.ack_i, a_e, a_run, a_fail);
        mdl_step(1, b_rstn, bif.req_i, &bif.ack_i, b_e, b_run, b_fail);
        if (!a_rstn) a_valid = 1;
        if (!b_rstn) b_valid = 1;
    end

    // Compare every output of both instances against the model each cycle.
    always @(negedge clk) begin
        if (a_valid) begin
            a_x = expect_of(4, a_e, a_run, a_fail);
            a_g = {aif.rst_no, aif.busy_o, aif.done_o, aif.timeout_o, aif.state_o};
            n_chk++;
            if (a_g !== a_x) begin
                n_fail++;
                $display("FAIL cycle_a t=%0t: got rst=%b busy=%b done=%b tmo=%b st=%0d, expected rst=%b busy=%b done=%b tmo=%b st=%0d",
                         $time, a_g.rstn, a_g.busy, a_g.done, a_g.tmo, a_g.st,
                         a_x.rstn, a_x.busy, a_x.done, a_x.tmo, a_x.st);
            end
        end
        if (b_valid) begin
            b_x = expect_of(1, b_e, b_run, b_fail);
            b_g = {3'b000, bif.rst_no, bif.busy_o, bif.done_o, bif.timeout_o, bif.state_o};
            n_chk++;
            if (b_g !== b_x) begin
                n_fail++;
                $display("FAIL cycle_b t=%0t: got rst=%b busy=%b done=%b tmo=%b st=%0d, expected rst=%b busy=%b done=%b tmo=%b st=%0d",
                         $time, b_g.rstn, b_g.busy, b_g.done, b_g.tmo, b_g.st,
                         b_x.rstn, b_x.busy, b_x.done, b_x.tmo, b_x.st);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end else begin
            $display("check %s ok (%0h)", name, got);
        end
    endtask

    // Advance n rising edges, then settle just after the last one.
    task automatic adv(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_req_a();
        aif.req_i = 1'b1;
        adv(1);
        aif.req_i = 1'b0;
    endtask

    initial begin
        a_rstn = 1'b0; b_rstn = 1'b0;
        aif.req_i = 1'b0; aif.ack_i = 4'hF;
        bif.req_i = 1'b0; bif.ack_i = 1'b1;
        adv(2);
        chk("reset_rst_no", 32'(aif.rst_no), 32'h0);
        chk("reset_busy", 32'(aif.busy_o), 32'h1);
        chk("reset_done", 32'(aif.done_o), 32'h0);
        chk("reset_timeout", 32'(aif.timeout_o), 32'h0);
        chk("reset_state", 32'(aif.state_o), 32'h0);

        // Normal bring-up with all acks high.
        a_rstn = 1'b1;
        adv(24); chk("t1_e24_rst", 32'(aif.rst_no), 32'h0);
        adv(1);  chk("t1_e25_rst", 32'(aif.rst_no), 32'h1);
        adv(4);  chk("t1_e29_rst", 32'(aif.rst_no), 32'h3);
        adv(4);  chk("t1_e33_rst", 32'(aif.rst_no), 32'h7);
        adv(4);  chk("t1_e37_rst", 32'(aif.rst_no), 32'hF);
                 chk("t1_e37_done", 32'(aif.done_o), 32'h0);
        adv(1);  chk("t1_e38_done", 32'(aif.done_o), 32'h1);
                 chk("t1_e38_busy", 32'(aif.busy_o), 32'h0);
                 chk("t1_e38_state", 32'(aif.state_o), 32'h3);

        // One-cycle request at edge 100 while running.
        adv(61);
        aif.req_i = 1'b1;
        adv(1);  chk("t3_e100_rst", 32'(aif.rst_no), 32'h0);
                 chk("t3_e100_done", 32'(aif.done_o), 32'h0);
                 chk("t3_e100_state", 32'(aif.state_o), 32'h0);
        aif.req_i = 1'b0;
        adv(24); chk("t3_e124_rst", 32'(aif.rst_no), 32'h0);
        adv(1);  chk("t3_e125_rst", 32'(aif.rst_no), 32'h1);
        adv(12); chk("t3_e137_done", 32'(aif.done_o), 32'h0);
        adv(1);  chk("t3_e138_done", 32'(aif.done_o), 32'h1);

        // Reset pulse at edge 30, mid-release.
        pulse_req_a();
        adv(29); chk("t4_e29_rst", 32'(aif.rst_no), 32'h3);
        a_rstn = 1'b0;
        adv(1);  chk("t4_e30_rst", 32'(aif.rst_no), 32'h0);
                 chk("t4_e30_state", 32'(aif.state_o), 32'h0);
        a_rstn = 1'b1;
        adv(24); chk("t4_restart_e24", 32'(aif.rst_no), 32'h0);
        adv(1);  chk("t4_restart_e25", 32'(aif.rst_no), 32'h1);

        // Domain 2 never acks: timeout at edge 200, sticky.
        aif.ack_i = 4'hB;
        pulse_req_a();
        adv(199); chk("t2_e199_rst", 32'(aif.rst_no), 32'hF);
                  chk("t2_e199_tmo", 32'(aif.timeout_o), 32'h0);
                  chk("t2_e199_state", 32'(aif.state_o), 32'h2);
        adv(1);   chk("t2_e200_rst", 32'(aif.rst_no), 32'h0);
                  chk("t2_e200_tmo", 32'(aif.timeout_o), 32'h1);
                  chk("t2_e200_done", 32'(aif.done_o), 32'h0);
                  chk("t2_e200_state", 32'(aif.state_o), 32'h4);
        adv(1000); chk("t2_sticky_tmo", 32'(aif.timeout_o), 32'h1);
                   chk("t2_sticky_rst", 32'(aif.rst_no), 32'h0);

        // Request held 10 cycles out of FAIL.
        aif.req_i = 1'b1;
        adv(1);  chk("t6_req1_tmo", 32'(aif.timeout_o), 32'h0);
                 chk("t6_req1_rst", 32'(aif.rst_no), 32'h0);
        adv(9);  chk("t6_req10_rst", 32'(aif.rst_no), 32'h0);
                 chk("t6_req10_state", 32'(aif.state_o), 32'h0);
        aif.ack_i = 4'hF;
        aif.req_i = 1'b0;
        adv(24); chk("t6_e24_rst", 32'(aif.rst_no), 32'h0);
        adv(1);  chk("t6_e25_rst", 32'(aif.rst_no), 32'h1);
        adv(13); chk("t6_e38_done", 32'(aif.done_o), 32'h1);

        // Acks first seen at edge 199: completes just inside the budget.
        aif.ack_i = 4'h0;
        pulse_req_a();
        adv(198); chk("t5_e198_done", 32'(aif.done_o), 32'h0);
        aif.ack_i = 4'hF;
        adv(1);   chk("t5_e199_done", 32'(aif.done_o), 32'h1);
                  chk("t5_e199_state", 32'(aif.state_o), 32'h3);
        adv(50);  chk("t5_late_tmo", 32'(aif.timeout_o), 32'h0);

        // Acks first seen at edge 200: completion beats the timeout.
        aif.ack_i = 4'h0;
        pulse_req_a();
        adv(199); chk("tb_e199_tmo", 32'(aif.timeout_o), 32'h0);
        aif.ack_i = 4'hF;
        adv(1);   chk("tb_e200_done", 32'(aif.done_o), 32'h1);
                  chk("tb_e200_tmo", 32'(aif.timeout_o), 32'h0);
                  chk("tb_e200_state", 32'(aif.state_o), 32'h3);

        // Ack drop while running is ignored.
        aif.ack_i = 4'h0;
        adv(5);   chk("run_ack_drop_done", 32'(aif.done_o), 32'h1);

        // Single-domain instance.
        b_rstn = 1'b1;
        adv(24); chk("n1_e24_rst", 32'(bif.rst_no), 32'h0);
        adv(1);  chk("n1_e25_rst", 32'(bif.rst_no), 32'h1);
                 chk("n1_e25_state", 32'(bif.state_o), 32'h2);
                 chk("n1_e25_done", 32'(bif.done_o), 32'h0);
        adv(1);  chk("n1_e26_done", 32'(bif.done_o), 32'h1);
        bif.req_i = 1'b1;
        adv(10); chk("n1_req_rst", 32'(bif.rst_no), 32'h0);
        bif.req_i = 1'b0;
        adv(25); chk("n1_rereq_e25_rst", 32'(bif.rst_no), 32'h1);
        adv(1);  chk("n1_rereq_e26_done", 32'(bif.done_o), 32'h1);

        adv(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
